// File: rtl/fpmul_arb_pkg.sv
// Shared types and helpers for the FPmul round-robin arbiter.
package fpmul_arb_pkg;

  localparam int FPW     = 32;
  localparam int MAX_IDW = 3;

  typedef struct packed {
    logic [FPW-1:0]     z;
    logic [MAX_IDW-1:0] id;
  } res_entry_t;

  function automatic int idw_f(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fpmul_arb_fifo.sv
// Show-ahead synchronous result FIFO with occupancy count; async active-high reset.
module fpmul_arb_fifo
  import fpmul_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  res_entry_t    i_wdata,
  input  logic          i_pop,
  output res_entry_t    o_rdata,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  res_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage, pointers and count; memory is cleared so the head reads zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin issue of NREQ operand streams into one non-stallable FPmul, with id tag pipe,
// credit-based result FIFO and tagged output. Optional counters: FPMUL_ARB_STATS_EN.
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int IDW     = idw_f(NREQ)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req_valid,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [NREQ*FPW-1:0] i_req_a,
  input  logic [NREQ*FPW-1:0] i_req_b,
  output logic [FPW-1:0]      o_mul_a,
  output logic [FPW-1:0]      o_mul_b,
  input  logic [FPW-1:0]      i_mul_z,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [FPW-1:0]      o_res_z,
  output logic [IDW-1:0]      o_res_id,
  output logic                o_busy
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [31:0]         o_issue_cnt,
  output logic [31:0]         o_stall_cnt
`endif
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(DEPTH + LATENCY + 2);

  logic [LATENCY:0] r_v;
  logic [IDW-1:0]   r_id [LATENCY+1];
  logic [IDW-1:0]   r_ptr;
  logic             r_busy;

  logic [FCW-1:0]   w_count;
  logic             w_empty;
  res_entry_t       w_head;
  res_entry_t       w_wentry;
  logic [OCW-1:0]   w_pipe_lo;
  logic [OCW-1:0]   w_occ;
  logic [OCW-1:0]   w_count_nxt;
  logic             w_credit;
  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt;
  logic             w_hs;
  logic             w_pop;
  logic             w_busy_nxt;
  logic             w_id_unused;

  // Occupancy from registered state only: tag pipe entries plus buffered results.
  always_comb begin
    w_pipe_lo = '0;
    for (int j = 0; j < LATENCY; j++) w_pipe_lo = w_pipe_lo + OCW'(r_v[j]);
    w_occ    = w_pipe_lo + OCW'(r_v[LATENCY]) + OCW'(w_count);
    w_credit = (w_occ < OCW'(DEPTH));
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_gnt_vld && w_credit && i_req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = IDW'(idx);
      end else begin
        w_gnt = w_gnt;
      end
    end
  end

  assign w_hs = w_gnt_vld && !i_rst;

  // One-hot accept for the granted requester.
  always_comb begin
    o_req_ready = '0;
    if (w_hs) begin
      o_req_ready[w_gnt] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  assign w_pop       = !w_empty && i_res_ready;
  assign w_count_nxt = OCW'(w_count) + OCW'(r_v[LATENCY]) - OCW'(w_pop);
  assign w_busy_nxt  = w_hs || (w_pipe_lo != '0) || (w_count_nxt != '0);
  assign w_wentry    = '{z: i_mul_z, id: MAX_IDW'(r_id[LATENCY])};

  // Operand issue, tag pipe shift, RR pointer and busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v     <= '0;
      for (int j = 0; j <= LATENCY; j++) r_id[j] <= '0;
      r_ptr   <= IDW'(NREQ - 1);
      o_mul_a <= '0;
      o_mul_b <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_v     <= {r_v[LATENCY-1:0], w_hs};
      r_id[0] <= w_gnt;
      for (int j = 1; j <= LATENCY; j++) r_id[j] <= r_id[j-1];
      if (w_hs) begin
        o_mul_a <= i_req_a[FPW*w_gnt +: FPW];
        o_mul_b <= i_req_b[FPW*w_gnt +: FPW];
        r_ptr   <= w_gnt;
      end else begin
        r_ptr   <= r_ptr;
      end
      r_busy <= w_busy_nxt;
    end
  end

  fpmul_arb_fifo #(.DEPTH(DEPTH), .CW(FCW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_v[LATENCY]),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_res_valid = !w_empty;
  assign o_res_z     = w_head.z;
  assign o_res_id    = w_head.id[IDW-1:0];
  assign o_busy      = r_busy;
  assign w_id_unused = ^w_head.id;

`ifdef FPMUL_ARB_STATS_EN
  // Wrap-around handshake and credit-stall counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_issue_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (w_hs) begin
        o_issue_cnt <= o_issue_cnt + 32'd1;
      end
      if ((|i_req_valid) && !w_credit) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed/randomized bench for fpmul_arbiter with a scoreboard model and an emulated FPmul.
module tb_fpmul_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [31:0]       mul_z;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_z;
  logic [1:0]        res_id;
  logic              busy;
`ifdef FPMUL_ARB_STATS_EN
  logic [31:0]       issue_cnt;
  logic [31:0]       stall_cnt;
`endif

  fpmul_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_z     (mul_z),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_z     (res_z),
    .o_res_id    (res_id),
    .o_busy      (busy)
`ifdef FPMUL_ARB_STATS_EN
    ,
    .o_issue_cnt (issue_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Exact for normal operands with short significands (the only kind the bench generates).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [10:0] ea, eb, ez;
    logic [63:0] d;
    real ra, rb;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    ea = {3'd0, a[30:23]} + 11'd896;
    eb = {3'd0, b[30:23]} + 11'd896;
    ra = $bitstoreal({a[31], ea, a[22:0], 29'd0});
    rb = $bitstoreal({b[31], eb, b[22:0], 29'd0});
    d  = $realtobits(ra * rb);
    ez = d[62:52] - 11'd896;
    return {d[63], ez[7:0], d[51:29]};
  endfunction

  logic [31:0] fp_pipe [LATENCY];
  always @(posedge clk) begin
    fp_pipe[0] <= fmul(mul_a, mul_b);
    for (int j = 1; j < LATENCY; j++) fp_pipe[j] <= fp_pipe[j-1];
  end
  assign mul_z = fp_pipe[LATENCY-1];

  typedef struct {
    logic [31:0] z;
    int          id;
    int          arrive;
  } exp_t;

  exp_t        q[$];
  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];
  logic [31:0] m_a, m_b;
  int          m_ptr, cyc, m_issue, m_stall, dut_hs;
  int          n_cmp = 0;
  int          n_err = 0;
  int          hs0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(110, 144)), 8'($urandom), 15'd0};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = rnd_fp();
      b_arr[i] = rnd_fp();
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = NREQ - 1;
    m_a     = 32'd0;
    m_b     = 32'd0;
    cyc     = 0;
    m_issue = 0;
    m_stall = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_mul_a"}, mul_a, 32'd0);
    chk({tag, "_mul_b"}, mul_b, 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_z"}, res_z, 32'd0);
    chk({tag, "_res_id"}, 32'(res_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int              g, idx;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv, pop;
    exp_t            e;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = a_arr[i];
      req_b[32*i +: 32] = b_arr[i];
    end
    @(negedge clk);
    g = -1;
    if (q.size() < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = (q.size() > 0) && (q[0].arrive <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("res_z", res_z, q[0].z);
      chk("res_id", 32'(res_id), 32'(q[0].id));
    end
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("mul_a", mul_a, m_a);
    chk("mul_b", mul_b, m_b);
`ifdef FPMUL_ARB_STATS_EN
    chk("issue_cnt", issue_cnt, 32'(m_issue));
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    if ((req_ready & req_valid) != 4'd0) dut_hs++;
    pop = exp_rv && res_ready;
    @(posedge clk);
    cyc++;
    if (req_valid != 4'd0 && q.size() >= DEPTH) m_stall++;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      e.z      = fmul(a_arr[g], b_arr[g]);
      e.id     = g;
      e.arrive = cyc + LATENCY + 1;
      q.push_back(e);
      m_ptr = g;
      m_a   = a_arr[g];
      m_b   = b_arr[g];
      m_issue++;
    end
    #1;
  endtask

  initial begin
    dut_hs    = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b0;
    rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = a_arr[i];
      req_b[32*i +: 32] = b_arr[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Single op from requester 2: 2.0 x 3.0
    a_arr[2]  = 32'h40000000;
    b_arr[2]  = 32'h40400000;
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0000;
    repeat (5) cycle();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_z", res_z, 32'h40C00000);
    chk("single_id", 32'(res_id), 32'd2);
    res_ready = 1'b1;
    cycle();
    chk("single_busy_low", 32'(busy), 32'd0);

    // Full contention, random operands
    req_valid = 4'hF;
    hs0 = dut_hs;
    repeat (40) begin
      rand_ops();
      cycle();
    end
    chk("contention_hs", 32'(dut_hs - hs0), 32'd40);
    req_valid = 4'h0;
    repeat (8) cycle();

    // Back-pressure: requester 0 streams into a stalled output
    res_ready = 1'b0;
    req_valid = 4'b0001;
    hs0 = dut_hs;
    repeat (20) begin
      rand_ops();
      cycle();
    end
    chk("backpressure_hs", 32'(dut_hs - hs0), 32'(DEPTH));
    res_ready = 1'b1;
    repeat (20) begin
      rand_ops();
      cycle();
    end
    req_valid = 4'h0;
    repeat (10) cycle();

    // Fairness between requesters 1 and 3 with an idle gap
    req_valid = 4'b1010;
    repeat (6) cycle();
    req_valid = 4'b0000;
    repeat (3) cycle();
    req_valid = 4'b1010;
    repeat (4) cycle();

    // Random valid patterns and output back-pressure
    repeat (120) begin
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      cycle();
    end
    req_valid = 4'h0;
    res_ready = 1'b1;
    repeat (20) cycle();

    // Reset while operations are in flight
    req_valid = 4'b0001;
    repeat (3) begin
      rand_ops();
      cycle();
    end
    req_valid = 4'b0000;
    cycle();
    rst = 1'b1;
    #2;
    chk_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    res_ready = 1'b0;
    repeat (10) cycle();
    chk("post_reset_valid", 32'(res_valid), 32'd0);

    // Concurrent sign/value case: requester 0 wins first after reset
    a_arr[0]  = 32'h41200000;
    b_arr[0]  = 32'h41200000;
    a_arr[1]  = 32'h3F800000;
    b_arr[1]  = 32'hBFC00000;
    req_valid = 4'b0011;
    res_ready = 1'b1;
    cycle();
    cycle();
    req_valid = 4'b0000;
    repeat (4) cycle();
    chk("sign_first_z", res_z, 32'h42C80000);
    chk("sign_first_id", 32'(res_id), 32'd0);
    cycle();
    chk("sign_second_z", res_z, 32'hBFC00000);
    chk("sign_second_id", 32'(res_id), 32'd1);
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
